// File: rtl/z80_bus_frontend.sv
// Z80 peripheral bus front end: synchronizes and de-glitches the asynchronous Z80 strobes,
// decodes a two-byte I/O window and turns bus cycles into single-cycle read/write events.
module z80_bus_frontend #(
    parameter int FILTER_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       z80_write_strobe_b,
    input  logic       z80_read_strobe_b,
    input  logic [7:0] z80_address_bus,
    input  logic [7:0] z80_data_bus_in,
    input  logic [7:0] base_address,
    input  logic [7:0] read_data_0,
    input  logic [7:0] read_data_1,
    output logic [7:0] z80_data_bus_out,
    output logic       z80_bus_dir,
    output logic       wr_stb,
    output logic       wr_offset,
    output logic [7:0] wr_data,
    output logic       rd_stb,
    output logic       rd_offset,
    output logic       protocol_error
);

    typedef enum logic [1:0] {
        IDLE,
        WR_ACTIVE,
        RD_ACTIVE,
        WAIT_RELEASE
    } state_e;

    localparam int WR = 0;
    localparam int RD = 1;
    localparam logic [3:0] FILT_LAST = 4'(FILTER_CYCLES - 1);

    // Strobe vectors are indexed [WR]/[RD] and stay active-low until the filter.
    logic [1:0] strb_meta_q, strb_sync_q;
    logic [7:0] addr_meta_q, addr_sync_q;
    logic [7:0] data_meta_q, data_sync_q;

    // NOTE: strobe synchronizer flops reset to 1 (idle) so leaving reset never looks like a bus cycle.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            strb_meta_q <= 2'b11;
            strb_sync_q <= 2'b11;
            addr_meta_q <= 8'h00;
            addr_sync_q <= 8'h00;
            data_meta_q <= 8'h00;
            data_sync_q <= 8'h00;
        end else begin
            strb_meta_q <= {z80_read_strobe_b, z80_write_strobe_b};
            strb_sync_q <= strb_meta_q;
            addr_meta_q <= z80_address_bus;
            addr_sync_q <= addr_meta_q;
            data_meta_q <= z80_data_bus_in;
            data_sync_q <= data_meta_q;
        end
    end

    // act_q is the filtered, active-high strobe level; any sample agreeing with it restarts the count.
    logic [1:0] act_q;
    logic [3:0] cnt_q [2];

    // NOTE: sequential state is only ever assigned with <=, so block order cannot change behaviour.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            act_q <= 2'b00;
            for (int i = 0; i < 2; i++) cnt_q[i] <= 4'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (strb_sync_q[i] == act_q[i]) begin
                    if (cnt_q[i] == FILT_LAST) begin
                        act_q[i] <= ~act_q[i];
                        cnt_q[i] <= 4'd0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 4'd1;
                    end
                end else begin
                    cnt_q[i] <= 4'd0;
                end
            end
        end
    end

    logic [7:0] base_plus1;
    logic       hit0, hit1, hit;

    assign base_plus1 = base_address + 8'd1;
    assign hit0       = (addr_sync_q == base_address);
    assign hit1       = (addr_sync_q == base_plus1);
    assign hit        = hit0 | hit1;

    state_e     state_q;
    logic [7:0] dout_q, wr_data_q;
    logic       dir_q, wr_stb_q, wr_off_q, rd_stb_q, rd_off_q, err_q;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= IDLE;
            dout_q    <= 8'h00;
            wr_data_q <= 8'h00;
            dir_q     <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_off_q  <= 1'b0;
            rd_stb_q  <= 1'b0;
            rd_off_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_stb_q <= 1'b0;
            rd_stb_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (act_q[WR] && act_q[RD]) begin
                        err_q   <= 1'b1;
                        state_q <= WAIT_RELEASE;
                    end else if (act_q[WR]) begin
                        if (hit) begin
                            wr_off_q <= hit1;
                            state_q  <= WR_ACTIVE;
                        end else begin
                            state_q <= WAIT_RELEASE;
                        end
                    end else if (act_q[RD]) begin
                        if (hit) begin
                            dout_q   <= hit1 ? read_data_1 : read_data_0;
                            dir_q    <= 1'b1;
                            rd_stb_q <= 1'b1;
                            rd_off_q <= hit1;
                            state_q  <= RD_ACTIVE;
                        end else begin
                            state_q <= WAIT_RELEASE;
                        end
                    end
                end
                WR_ACTIVE: begin
                    if (!strb_sync_q[WR]) wr_data_q <= data_sync_q;
                    if (act_q[RD]) begin
                        err_q   <= 1'b1;
                        dir_q   <= 1'b0;
                        state_q <= WAIT_RELEASE;
                    end else if (!act_q[WR]) begin
                        wr_stb_q <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                RD_ACTIVE: begin
                    if (act_q[WR]) begin
                        err_q   <= 1'b1;
                        dir_q   <= 1'b0;
                        state_q <= WAIT_RELEASE;
                    end else if (!act_q[RD]) begin
                        dir_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                WAIT_RELEASE: begin
                    if (!act_q[WR] && !act_q[RD]) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign z80_data_bus_out = dout_q;
    assign z80_bus_dir      = dir_q;
    assign wr_stb           = wr_stb_q;
    assign wr_offset        = wr_off_q;
    assign wr_data          = wr_data_q;
    assign rd_stb           = rd_stb_q;
    assign rd_offset        = rd_off_q;
    assign protocol_error   = err_q;

endmodule

// File: doc/z80_bus_frontend.md
Z80_BUS_FRONTEND -- requirements
Module: z80_bus_frontend

Interface
REQ-001 SHALL have parameter FILTER_CYCLES, default 2, legal range 1..15: consecutive synchronized samples needed to accept a strobe edge.
REQ-002 SHALL have port clk, input, 1: single clock, rising edge.
REQ-003 SHALL have port reset_b, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port z80_write_strobe_b, input, 1: asynchronous Z80 write strobe, active low.
REQ-005 SHALL have port z80_read_strobe_b, input, 1: asynchronous Z80 read strobe, active low.
REQ-006 SHALL have port z80_address_bus, input, 8: asynchronous low address byte.
REQ-007 SHALL have port z80_data_bus_in, input, 8: asynchronous Z80 write data.
REQ-008 SHALL have port base_address, input, 8: quasi-static decode base; the window is base and base+1, with base+1 computed mod 256.
REQ-009 SHALL have port read_data_0, input, 8: byte returned for reads at offset 0.
REQ-010 SHALL have port read_data_1, input, 8: byte returned for reads at offset 1.
REQ-011 SHALL have port z80_data_bus_out, output, 8: registered read data.
REQ-012 SHALL have port z80_bus_dir, output, 1: high while the transceiver drives the Z80 bus.
REQ-013 SHALL have port wr_stb, output, 1: one-cycle pulse on completion of a decoded write.
REQ-014 SHALL have port wr_offset, output, 1: offset of the completed write, valid with wr_stb.
REQ-015 SHALL have port wr_data, output, 8: data of the completed write, valid with wr_stb.
REQ-016 SHALL have port rd_stb, output, 1: one-cycle pulse when a decoded read is accepted.
REQ-017 SHALL have port rd_offset, output, 1: offset of the accepted read, valid with rd_stb.
REQ-018 SHALL have port protocol_error, output, 1: one-cycle pulse on an illegal strobe combination.

Function
REQ-019 SHALL pass both strobes, the address and the data through 2-flop synchronizers; strobe flops reset to 1.
REQ-020 SHALL, per strobe, assert the filtered level after FILTER_CYCLES consecutive synchronized-low samples, and deassert it after FILTER_CYCLES consecutive synchronized-high samples.
REQ-021 SHALL implement the states IDLE, WR_ACTIVE, RD_ACTIVE and WAIT_RELEASE.
REQ-022 SHALL, in IDLE with both filtered strobes asserted in the same cycle, pulse protocol_error and go to WAIT_RELEASE.
REQ-023 SHALL, in IDLE with filtered write asserted and the synchronized address in the window, latch the offset and go to WR_ACTIVE; an address outside the window SHALL go to WAIT_RELEASE.
REQ-024 SHALL, in WR_ACTIVE, capture synchronized data into wr_data on every cycle the synchronized write strobe is low.
REQ-025 SHALL, in WR_ACTIVE, on filtered write deassertion, pulse wr_stb with wr_offset and wr_data for one cycle and return to IDLE.
REQ-026 SHALL, in IDLE with filtered read asserted and the address in the window, load z80_data_bus_out from read_data_<offset>, set z80_bus_dir, pulse rd_stb and go to RD_ACTIVE, all on the same edge.
REQ-027 SHALL, in IDLE with filtered read asserted and the address outside the window, go to WAIT_RELEASE with z80_bus_dir held low.
REQ-028 SHALL hold z80_data_bus_out constant throughout RD_ACTIVE, even if read_data_* change.
REQ-029 SHALL, in RD_ACTIVE, on filtered read deassertion, clear z80_bus_dir on that edge and return to IDLE.
REQ-030 SHALL, in RD_ACTIVE or WR_ACTIVE, on assertion of the opposite filtered strobe, pulse protocol_error, clear z80_bus_dir, suppress wr_stb and go to WAIT_RELEASE.
REQ-031 SHALL leave WAIT_RELEASE for IDLE only when both filtered strobes are deasserted.
REQ-032 SHALL assert z80_bus_dir and rd_stb exactly FILTER_CYCLES+3 rising edges after the edge that first samples the raw read strobe low, counting that edge.
REQ-033 SHALL assert wr_stb exactly FILTER_CYCLES+3 rising edges after the edge that first samples the raw write strobe high, under the same counting.
REQ-034 SHALL restart the filter count on any strobe glitch shorter than FILTER_CYCLES synchronized samples, producing no state change.

Reset
REQ-035 SHALL, while reset_b is low, asynchronously force state IDLE, filter counters to 0, filtered strobes deasserted, and every output to 0 (z80_data_bus_out 8'h00).
REQ-036 SHALL, on reset asserted mid-read, drop z80_bus_dir immediately, without waiting for a clock edge.
REQ-037 SHALL, on reset asserted mid-write, never emit wr_stb for that write.

Verification
REQ-038 SHALL cover: base 8'h80, write 8'hA5 to 8'h81 with strobe low 10 cycles -> one wr_stb, wr_offset 1, wr_data 8'hA5, FILTER_CYCLES+3 edges after strobe release.
REQ-039 SHALL cover: read at 8'h80 with read_data_0 = 8'h3C -> z80_bus_dir high and z80_data_bus_out 8'h3C FILTER_CYCLES+3 edges after strobe fall, one rd_stb, bus_dir low after release.
REQ-040 SHALL cover: base 8'hFF, read at 8'h00 -> offset-1 hit (wrap); read at 8'h7F with base 8'h80 -> no bus_dir, no rd_stb.
REQ-041 SHALL cover: 1-cycle write-strobe glitch with FILTER_CYCLES=2 -> no wr_stb and no state change.
REQ-042 SHALL cover: write strobe asserted during an active read -> protocol_error pulse, bus_dir low, no wr_stb, IDLE after both strobes release.
REQ-043 SHALL cover: reset_b pulsed low mid-read -> bus_dir low with no clock edge; the next read at 8'h80 works normally.
